// File: rtl/joystick_pkg.sv
// Shared types and defaults for the joystick input conditioner.
// Optional auto-repeat is enabled with the JOY_AUTOREPEAT_EN macro.
package joystick_pkg;

    typedef enum logic [1:0] {
        REL   = 2'd0,
        CHK_P = 2'd1,
        PRS   = 2'd2,
        CHK_R = 2'd3
    } joy_state_e;

    localparam int DEF_DEB_CYCLES    = 250000;
    localparam int DEF_REPEAT_DELAY  = 25000000;
    localparam int DEF_REPEAT_PERIOD = 5000000;

    // Ceiling log2 with a floor of 1 so single-value ranges still get a bit.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/joystick_debounce_ch.sv
// One input channel: 2-FF synchroniser, debounce FSM and press/release pulses.
// JOY_AUTOREPEAT_EN adds a hold counter that re-emits o_press while held.
module joystick_debounce_ch
    import joystick_pkg::*;
#(
    parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
    parameter int ACTIVE_LOW    = 0,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_pin,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int             CW       = clog2(DEB_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);

    logic            r_sync1;
    logic            r_sync2;
    joy_state_e      r_state;
    logic [CW-1:0]   r_cnt;
    logic            w_synced;
    logic            w_repeat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
        end
    end

    assign w_synced = r_sync2 ^ (ACTIVE_LOW != 0);

`ifdef JOY_AUTOREPEAT_EN
    localparam int             HMAX       = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int             HW         = clog2(HMAX);
    localparam logic [HW-1:0]  HOLD_FIRST = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0]  HOLD_NEXT  = HW'(REPEAT_PERIOD - 1);

    logic [HW-1:0] r_hold;
    logic          r_repeating;
    logic [HW-1:0] w_hold_limit;

    assign w_hold_limit = r_repeating ? HOLD_NEXT : HOLD_FIRST;
    assign w_repeat     = (r_state == PRS) && w_synced && (r_hold == w_hold_limit);

    // Hold time is measured only over uninterrupted PRS cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold      <= '0;
            r_repeating <= 1'b0;
        end else if ((r_state == PRS) && w_synced) begin
            if (r_hold == w_hold_limit) begin
                r_hold      <= '0;
                r_repeating <= 1'b1;
            end else begin
                r_hold <= r_hold + HW'(1);
            end
        end else begin
            r_hold      <= '0;
            r_repeating <= 1'b0;
        end
    end
`else
    assign w_repeat = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= REL;
            r_cnt     <= '0;
            o_level   <= 1'b0;
            o_press   <= 1'b0;
            o_release <= 1'b0;
        end else begin
            o_press   <= w_repeat;
            o_release <= 1'b0;
            case (r_state)
                REL: begin
                    if (w_synced) begin
                        r_state <= CHK_P;
                        r_cnt   <= CW'(1);
                    end
                end
                CHK_P: begin
                    if (!w_synced) begin
                        r_state <= REL;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= PRS;
                        r_cnt   <= '0;
                        o_level <= 1'b1;
                        o_press <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                PRS: begin
                    if (!w_synced) begin
                        r_state <= CHK_R;
                        r_cnt   <= CW'(1);
                    end
                end
                CHK_R: begin
                    if (w_synced) begin
                        r_state <= PRS;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state   <= REL;
                        r_cnt     <= '0;
                        o_level   <= 1'b0;
                        o_release <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= REL;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/joystick_conditioner.sv
// N-channel joystick/button conditioner with a one-deep valid/ready event register.
// Define JOY_AUTOREPEAT_EN to enable auto-repeat press pulses while a button is held.
module joystick_conditioner
    import joystick_pkg::*;
#(
    parameter int N_CH          = 5,
    parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
    parameter int ACTIVE_LOW    = 0,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    localparam int CH_W         = clog2(N_CH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] i_btn,
    output logic [N_CH-1:0] o_level,
    output logic [N_CH-1:0] o_press,
    output logic [N_CH-1:0] o_release,
    output logic            o_evt_valid,
    output logic [CH_W-1:0] o_evt_ch,
    output logic            o_evt_rel,
    input  logic            i_evt_ready,
    output logic            o_evt_ovf
);

    logic [N_CH-1:0] w_press;
    logic [N_CH-1:0] w_release;
    logic [N_CH-1:0] w_evt_bits;
    logic [CH_W-1:0] w_win_ch;
    logic            w_win_rel;
    logic            w_any;
    logic            w_multi;
    logic            w_can_load;

    logic            r_evt_valid;
    logic [CH_W-1:0] r_evt_ch;
    logic            r_evt_rel;
    logic            r_evt_ovf;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        joystick_debounce_ch #(
            .DEB_CYCLES   (DEB_CYCLES),
            .ACTIVE_LOW   (ACTIVE_LOW),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_pin    (i_btn[g]),
            .o_level  (o_level[g]),
            .o_press  (w_press[g]),
            .o_release(w_release[g])
        );
    end

    assign o_press    = w_press;
    assign o_release  = w_release;
    assign w_evt_bits = w_press | w_release;
    assign w_any      = |w_evt_bits;
    assign w_multi    = |(w_evt_bits & (w_evt_bits - N_CH'(1)));
    assign w_can_load = !r_evt_valid || i_evt_ready;

    // Descending scan so the lowest-index pulsing channel is the one left standing.
    always_comb begin
        w_win_ch  = '0;
        w_win_rel = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (w_evt_bits[i]) begin
                w_win_ch  = CH_W'(i);
                w_win_rel = w_release[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_evt_valid <= 1'b0;
            r_evt_ch    <= '0;
            r_evt_rel   <= 1'b0;
            r_evt_ovf   <= 1'b0;
        end else begin
            if (w_any && w_can_load) begin
                r_evt_valid <= 1'b1;
                r_evt_ch    <= w_win_ch;
                r_evt_rel   <= w_win_rel;
            end else if (r_evt_valid && i_evt_ready) begin
                r_evt_valid <= 1'b0;
            end
            if ((w_any && !w_can_load) || w_multi) begin
                r_evt_ovf <= 1'b1;
            end
        end
    end

    assign o_evt_valid = r_evt_valid;
    assign o_evt_ch    = r_evt_ch;
    assign o_evt_rel   = r_evt_rel;
    assign o_evt_ovf   = r_evt_ovf;

endmodule
